ps2_key_event: RTL and testbench
================================

// Module: ps2_key_event
// PURPOSE
//   Consumer stage behind ps2_keyboard. Drains its scan-code FIFO over the ready/nextdata_n
//   handshake and folds E0 (extended) and F0 (break) prefixes into one key event per key action.
//   Tracks the held key and counts key presses for the 7-seg display path.
// PARAMETERS
//   CNT_W        8      width of press_count; wraps modulo 2**CNT_W
//   PREFIX_TMO   2**20  clk cycles allowed between a prefix byte and its key byte before abort
// PORTS
//   clk          in   1      system clock; all logic on rising edge
//   clr          in   1      synchronous reset, active-high
//   ready        in   1      ps2_keyboard FIFO non-empty; data valid while high
//   data         in   8      scan byte at FIFO head
//   nextdata_n   out  1      active-low pop strobe to ps2_keyboard, exactly 1 cycle per byte
//   key_valid    out  1      1-cycle pulse: key_code/key_ext/key_break hold a new event
//   key_code     out  8      scan code of last event (prefixes stripped)
//   key_ext      out  1      last event was E0-prefixed
//   key_break    out  1      last event was a release (F0-prefixed)
//   key_down     out  1      level: a key is held (last make not yet released)
//   press_count  out  CNT_W  number of make events since reset
//   err          out  1      1-cycle pulse: discarded byte or prefix timeout
// BEHAVIOUR
//   Reset: nextdata_n=1, key_valid=0, key_code=8'h00, key_ext=0, key_break=0, key_down=0,
//     press_count=0, err=0, FSM=IDLE, prefix flags cleared, timeout counter 0. clr beats every event.
//   FSM states: IDLE, POP, GAP.
//     IDLE: if ready=1, latch data into byte_r -> POP.
//     POP: drive nextdata_n=0 for this cycle only -> GAP.
//     GAP: nextdata_n=1, ready ignored for one cycle (FIFO pointer settles) -> IDLE.
//     Max throughput is 1 byte per 3 cycles. nextdata_n stays 1 outside POP.
//   Byte decode happens in the POP cycle; outputs update on the edge that ends POP:
//     8'hE0 -> ext_f=1, no event.  8'hF0 -> brk_f=1, no event (F0 E0 also legal, sets ext_f).
//     8'h00, 8'hFF, 8'hAA -> discarded; ext_f=brk_f=0; err pulses.
//     other -> key_code=byte, key_ext=ext_f, key_break=brk_f, key_valid pulses,
//       then ext_f=brk_f=0.
//   Make event (brk_f=0): key_down=1; held code/ext recorded; press_count+1, wrap to 0 past max.
//   Break event: key_down cleared only if code+ext match the held key; otherwise unchanged.
//   Repeated prefixes (E0 E0, F0 F0) are idempotent.
//   Timeout: while ext_f|brk_f set and no byte is consumed for PREFIX_TMO cycles:
//     flags cleared, err pulses, no event.
//   The counter restarts on every consumed byte.
//   key_valid and err never assert in the same cycle. Outputs are registered; no combinational
//   path from ready/data to any output.
// CONFIGURATION
//   PS2_REPEAT_FILTER_EN defined: a make of a code+ext already held (typematic repeat) produces
//     no key_valid and no press_count increment. The first make after a matching break, or after
//     a different key's make, is reported normally.
//   Not defined: every make byte, repeats included, produces key_valid and increments press_count.
// TESTING
//   1. clr=1 while ready=1 and data=8'h1C -> nextdata_n stays 1, all outputs at reset values.
//   2. Feed 1C, F0 1C -> two key_valid pulses: (1C, ext=0, brk=0) then (1C, ext=0, brk=1).
//      key_down 1 then 0; press_count=1. Exactly 3 nextdata_n low pulses, each 1 cycle.
//   3. Feed E0 75, E0 F0 75 -> events (75, ext=1, brk=0) and (75, ext=1, brk=1).
//      press_count=1; no events on prefix bytes.
//   4. Feed 1C 1C 1C F0 1C -> with PS2_REPEAT_FILTER_EN: 2 events, press_count=1.
//      Without it: 4 events, press_count=3. key_down=0 at end in both builds.
//   5. Feed F0, then ready=0 for PREFIX_TMO cycles (use small PREFIX_TMO, e.g. 16), then 1C:
//      err pulses once at timeout; 1C reported as make (brk=0).
//   6. CNT_W=2, feed 5 distinct makes -> press_count 1,2,3,0,1. Feed 00 -> err pulse, no event.

Source files
------------

// File: rtl/ps2_key_event.sv
// Drains ps2_keyboard's scan FIFO and folds E0/F0 prefixes into one event per key action.
// Optional PS2_REPEAT_FILTER_EN: suppress typematic repeats of the currently held key.
module ps2_key_event #(
  parameter int CNT_W      = 8,
  parameter int PREFIX_TMO = 2**20
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ready,
  input  logic [7:0]       data,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  localparam int TMO_W = (PREFIX_TMO > 1) ? $clog2(PREFIX_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TMO - 1);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic               key_valid_q, key_valid_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               key_ext_q, key_ext_d;
  logic               key_break_q, key_break_d;
  logic               key_down_q, key_down_d;
  logic [7:0]         held_code_q, held_code_d;
  logic               held_ext_q, held_ext_d;
  logic [CNT_W-1:0]   press_count_q, press_count_d;
  logic               err_q, err_d;
  logic               ext_f_q, ext_f_d;
  logic               brk_f_q, brk_f_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               held_match;
  logic               drop_repeat;

  assign held_match = key_down_q && (held_code_q == byte_q) && (held_ext_q == ext_f_q);

`ifdef PS2_REPEAT_FILTER_EN
  assign drop_repeat = held_match;
`else
  assign drop_repeat = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    nextdata_n_d  = 1'b1;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_break_d   = key_break_q;
    key_down_d    = key_down_q;
    held_code_d   = held_code_q;
    held_ext_d    = held_ext_q;
    press_count_d = press_count_q;
    err_d         = 1'b0;
    ext_f_d       = ext_f_q;
    brk_f_d       = brk_f_q;
    tmo_cnt_d     = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (ready) begin
          byte_d       = data;
          state_d      = POP;
          nextdata_n_d = 1'b0;
        end
      end
      POP: begin
        state_d = GAP;
        if (byte_q == 8'hE0) begin
          ext_f_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_f_d = 1'b1;
        end else if (byte_q == 8'h00 || byte_q == 8'hFF || byte_q == 8'hAA) begin
          ext_f_d = 1'b0;
          brk_f_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          ext_f_d = 1'b0;
          brk_f_d = 1'b0;
          if (brk_f_q) begin
            key_valid_d = 1'b1;
            key_code_d  = byte_q;
            key_ext_d   = ext_f_q;
            key_break_d = 1'b1;
            if (held_match) begin
              key_down_d = 1'b0;
            end
          end else if (!drop_repeat) begin
            key_valid_d   = 1'b1;
            key_code_d    = byte_q;
            key_ext_d     = ext_f_q;
            key_break_d   = 1'b0;
            key_down_d    = 1'b1;
            held_code_d   = byte_q;
            held_ext_d    = ext_f_q;
            press_count_d = press_count_q + CNT_W'(1);
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout only advances outside POP, so it can never collide with a decode result.
    if (state_q == POP || !(ext_f_q || brk_f_q)) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      tmo_cnt_d = '0;
      ext_f_d   = 1'b0;
      brk_f_d   = 1'b0;
      err_d     = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= IDLE;
      byte_q        <= 8'h00;
      nextdata_n_q  <= 1'b1;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
      key_ext_q     <= 1'b0;
      key_break_q   <= 1'b0;
      key_down_q    <= 1'b0;
      held_code_q   <= 8'h00;
      held_ext_q    <= 1'b0;
      press_count_q <= '0;
      err_q         <= 1'b0;
      ext_f_q       <= 1'b0;
      brk_f_q       <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_break_q   <= key_break_d;
      key_down_q    <= key_down_d;
      held_code_q   <= held_code_d;
      held_ext_q    <= held_ext_d;
      press_count_q <= press_count_d;
      err_q         <= err_d;
      ext_f_q       <= ext_f_d;
      brk_f_q       <= brk_f_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign nextdata_n  = nextdata_n_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_break   = key_break_q;
  assign key_down    = key_down_q;
  assign press_count = press_count_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Bench for ps2_key_event: vector table, directed prefix/timeout sequences, randomized bytes vs model.
module tb_ps2_key_event;

  localparam int CNT_W = 2;
  localparam int TMO   = 16;
`ifdef PS2_REPEAT_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic             ready;
  logic [7:0]       data;
  logic             nextdata_n;
  logic             key_valid;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_break;
  logic             key_down;
  logic [CNT_W-1:0] press_count;
  logic             err;

  ps2_key_event #(.CNT_W(CNT_W), .PREFIX_TMO(TMO)) dut (
    .clk(clk), .clr(clr), .ready(ready), .data(data), .nextdata_n(nextdata_n),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_down(key_down), .press_count(press_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v; bit e; logic [7:0] code; bit ext; bit brk; bit down; int cnt;
  } obs_t;

  typedef struct {
    logic [7:0] b; bit v; bit e; logic [7:0] code; bit ext; bit brk; bit down; int cnt;
  } vec_t;

  int compared = 0;
  int mismatched = 0;
  int sent = 0;
  int nd_low = 0;
  int nd_double = 0;
  int both = 0;
  bit prev_low = 1'b0;

  // Model state: pending prefixes, held key, press count.
  bit         m_ext, m_brk, m_down, m_he;
  logic [7:0] m_hc;
  int         m_cnt;

  always @(negedge clk) begin
    if (nextdata_n === 1'b0) begin
      nd_low++;
      if (prev_low) nd_double++;
    end
    prev_low = (nextdata_n === 1'b0);
    if (key_valid === 1'b1 && err === 1'b1) both++;
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input obs_t got, input obs_t exp);
    check({tag, "_valid"}, int'(got.v), int'(exp.v));
    check({tag, "_err"}, int'(got.e), int'(exp.e));
    if (exp.v) begin
      check({tag, "_code"}, int'(got.code), int'(exp.code));
      check({tag, "_ext"}, int'(got.ext), int'(exp.ext));
      check({tag, "_brk"}, int'(got.brk), int'(exp.brk));
    end
    check({tag, "_down"}, int'(got.down), int'(exp.down));
    check({tag, "_cnt"}, got.cnt, exp.cnt);
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_down = 0; m_he = 0; m_hc = 8'h00; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output obs_t e);
    bit rep;
    e = '{default: 0};
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'h00 || b == 8'hFF || b == 8'hAA) begin
      e.e = 1; m_ext = 0; m_brk = 0;
    end else begin
      e.code = b; e.ext = m_ext; e.brk = m_brk;
      rep = m_down && (m_hc == b) && (m_he == m_ext);
      if (m_brk) begin
        e.v = 1;
        if (rep) m_down = 0;
      end else if (!(FILT && rep)) begin
        e.v = 1;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_down = 1; m_hc = b; m_he = m_ext;
      end
      m_ext = 0; m_brk = 0;
    end
    e.down = m_down;
    e.cnt = m_cnt;
  endtask

  task automatic do_reset();
    clr = 1'b1; ready = 1'b1; data = 8'h1C;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i > 0) check($sformatf("rst_nextdata_n_%0d", i), int'(nextdata_n), 1);
    end
    check("rst_valid", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_ext", int'(key_ext), 0);
    check("rst_brk", int'(key_break), 0);
    check("rst_down", int'(key_down), 0);
    check("rst_cnt", int'(press_count), 0);
    check("rst_err", int'(err), 0);
    clr = 1'b0; ready = 1'b0;
    model_reset();
  endtask

  // Acts as the FIFO: presents one byte until popped, returns the GAP-cycle outputs.
  task automatic send_byte(input logic [7:0] b, output obs_t o);
    int t = 0;
    o = '{default: 0};
    ready = 1'b1; data = b;
    do begin
      @(negedge clk); t++;
    end while (nextdata_n !== 1'b0 && t < 20);
    if (nextdata_n !== 1'b0) begin
      check("pop_wait_expired", 0, 1);
      ready = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ready = 1'b0; data = 8'($urandom);
    sent++;
    o.v = key_valid; o.e = err; o.code = key_code; o.ext = key_ext;
    o.brk = key_break; o.down = key_down; o.cnt = int'(press_count);
  endtask

  task automatic wait_idle(input int n, output int errs);
    errs = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (err === 1'b1) errs++;
    end
  endtask

  vec_t vecs[$];
  obs_t got, exp;
  int   errs, ev, nd0, idle_errs;

  initial begin
    clr = 1'b1; ready = 1'b0; data = 8'h00;
    vecs = '{
      '{8'h1C,1,0,8'h1C,0,0,1,1}, '{8'hF0,0,0,8'h00,0,0,1,1}, '{8'h1C,1,0,8'h1C,0,1,0,1},
      '{8'hE0,0,0,8'h00,0,0,0,1}, '{8'h75,1,0,8'h75,1,0,1,2}, '{8'hE0,0,0,8'h00,0,0,1,2},
      '{8'hF0,0,0,8'h00,0,0,1,2}, '{8'h75,1,0,8'h75,1,1,0,2}, '{8'h16,1,0,8'h16,0,0,1,3},
      '{8'h1E,1,0,8'h1E,0,0,1,0}, '{8'h26,1,0,8'h26,0,0,1,1}, '{8'h25,1,0,8'h25,0,0,1,2},
      '{8'h2E,1,0,8'h2E,0,0,1,3}, '{8'h00,0,1,8'h00,0,0,1,3}, '{8'hF0,0,0,8'h00,0,0,1,3},
      '{8'hAA,0,1,8'h00,0,0,1,3}, '{8'h1C,1,0,8'h1C,0,0,1,0}, '{8'hF0,0,0,8'h00,0,0,1,0},
      '{8'h2E,1,0,8'h2E,0,1,1,0}, '{8'hE0,0,0,8'h00,0,0,1,0}, '{8'h1C,1,0,8'h1C,1,0,1,1},
      '{8'hF0,0,0,8'h00,0,0,1,1}, '{8'h1C,1,0,8'h1C,0,1,1,1}, '{8'hE0,0,0,8'h00,0,0,1,1},
      '{8'hF0,0,0,8'h00,0,0,1,1}, '{8'h1C,1,0,8'h1C,1,1,0,1}, '{8'hE0,0,0,8'h00,0,0,0,1},
      '{8'hE0,0,0,8'h00,0,0,0,1}, '{8'h75,1,0,8'h75,1,0,1,2}, '{8'hF0,0,0,8'h00,0,0,1,2},
      '{8'hE0,0,0,8'h00,0,0,1,2}, '{8'h75,1,0,8'h75,1,1,0,2}
    };

    do_reset();
    nd0 = nd_low;
    foreach (vecs[i]) begin
      send_byte(vecs[i].b, got);
      exp = '{vecs[i].v, vecs[i].e, vecs[i].code, vecs[i].ext, vecs[i].brk,
              vecs[i].down, vecs[i].cnt};
      cmp($sformatf("vec%0d", i), got, exp);
      if (i == 2) check("first3_pop_pulses", nd_low - nd0, 3);
    end

    // Typematic repeat handling
    do_reset();
    ev = 0;
    foreach (vecs[i]) if (i < 5) begin
      logic [7:0] seq [5];
      seq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
      send_byte(seq[i], got);
      model_byte(seq[i], exp);
      cmp($sformatf("rep%0d", i), got, exp);
      if (got.v) ev++;
    end
    check("rep_events", ev, FILT ? 2 : 4);
    check("rep_cnt", int'(press_count), FILT ? 1 : 3);
    check("rep_down", int'(key_down), 0);

    // Prefix timeout: expires once, following key is a plain make
    do_reset();
    send_byte(8'hF0, got);
    wait_idle(3 * TMO, errs);
    check("tmo_brk_errs", errs, 1);
    send_byte(8'h1C, got);
    check("tmo_brk_valid", int'(got.v), 1);
    check("tmo_brk_brk", int'(got.brk), 0);
    check("tmo_brk_cnt", got.cnt, 1);
    send_byte(8'hE0, got);
    wait_idle(3 * TMO, errs);
    check("tmo_ext_errs", errs, 1);
    send_byte(8'h75, got);
    check("tmo_ext_ext", int'(got.ext), 0);
    check("tmo_ext_err_with_event", int'(got.e), 0);
    send_byte(8'hF0, got);
    wait_idle(TMO - 4, errs);
    check("notmo_errs", errs, 0);
    send_byte(8'h75, got);
    check("notmo_valid", int'(got.v), 1);
    check("notmo_brk", int'(got.brk), 1);
    check("notmo_err", int'(got.e), 0);

    // Randomized byte stream vs model, gaps kept well under the prefix timeout
    do_reset();
    idle_errs = 0;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] b;
      int sel;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4: begin
          case ($urandom_range(0, 2))
            0:       b = 8'h00;
            1:       b = 8'hFF;
            default: b = 8'hAA;
          endcase
        end
        5, 6:    b = 8'h1C;
        7:       b = 8'h1D;
        8:       b = 8'h75;
        9:       b = 8'h6B;
        default: b = 8'(8'h01 + $urandom_range(0, 8'h7E));
      endcase
      send_byte(b, got);
      model_byte(b, exp);
      if (got !== exp && !(exp.v == 0 && got.v == 0 && got.e == exp.e &&
                           got.down == exp.down && got.cnt == exp.cnt))
        cmp($sformatf("rnd%0d_b%02h", n, b), got, exp);
      else
        compared++;
      wait_idle($urandom_range(0, 3), errs);
      idle_errs += errs;
    end
    check("rnd_idle_errs", idle_errs, 0);

    wait_idle(4, errs);
    check("pop_pulses_total", nd_low, sent);
    check("pop_pulse_width", nd_double, 0);
    check("valid_err_overlap", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
